// File: rtl/lcd_receiver.sv
`default_nettype none
// ==== lcd_receiver : HD44780-style bus snooper with 32-entry DDRAM shadow ==== rev 1.0 ====
module lcd_receiver #(
  parameter int CLEAR_CYCLES = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       rs,
  input  logic [3:0] data,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       mode_4bit,
  output logic       two_line,
  output logic       display_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic [4:0] cursor_addr,
  output logic       char_wr,
  output logic       protocol_err,
  output logic       overrun_err
);

  localparam int CW = $clog2(CLEAR_CYCLES + 1);

  typedef enum logic {PH_HIGH = 1'b0, PH_LOW = 1'b1} phase_e;

  logic          en_q, rs_q;
  logic [3:0]    data_q;
  phase_e        phase_q, phase_d;
  logic [3:0]    hi_nib_q, hi_nib_d;
  logic          hi_rs_q, hi_rs_d;
  logic          mode_4bit_q, mode_4bit_d, two_line_q, two_line_d;
  logic          disp_q, disp_d, cur_q, cur_d, blink_q, blink_d;
  logic          inc_q, inc_d;
  logic [4:0]    ac_q, ac_d;
  logic          char_wr_q, char_wr_d;
  logic          perr_q, perr_d, oerr_q, oerr_d;
  logic          busy_q, busy_d;
  logic [CW-1:0] clr_cnt_q, clr_cnt_d;
  logic [7:0]    rd_data_q;
  logic [7:0]    mem_q [32];

  logic          w_strobe, w_byte_vld;
  logic [7:0]    w_byte;
  logic          w_mem_we;
  logic [4:0]    w_mem_waddr;
  logic [7:0]    w_mem_wdata;

  // A strobe is the falling edge of en; nibble and rs come from the last en-high cycle.
  assign w_strobe = en_q & ~en;

  always_comb begin
    phase_d     = phase_q;
    hi_nib_d    = hi_nib_q;
    hi_rs_d     = hi_rs_q;
    mode_4bit_d = mode_4bit_q;
    two_line_d  = two_line_q;
    disp_d      = disp_q;
    cur_d       = cur_q;
    blink_d     = blink_q;
    inc_d       = inc_q;
    ac_d        = ac_q;
    char_wr_d   = 1'b0;
    perr_d      = perr_q;
    oerr_d      = oerr_q;
    busy_d      = busy_q;
    clr_cnt_d   = clr_cnt_q;
    w_byte_vld  = 1'b0;
    w_byte      = 8'h00;
    w_mem_we    = 1'b0;
    w_mem_waddr = clr_cnt_q[4:0];
    w_mem_wdata = 8'h20;

    if (busy_q) begin
      w_mem_we  = (clr_cnt_q < CW'(32));
      clr_cnt_d = clr_cnt_q + CW'(1);
      if (clr_cnt_q == CW'(CLEAR_CYCLES - 1)) busy_d = 1'b0;
      if (w_strobe) oerr_d = 1'b1;
    end else if (w_strobe) begin
      if (!mode_4bit_q) begin
        w_byte_vld = 1'b1;
        w_byte     = {data_q, 4'h0};
      end else if (phase_q == PH_HIGH) begin
        hi_nib_d = data_q;
        hi_rs_d  = rs_q;
        phase_d  = PH_LOW;
      end else begin
        phase_d = PH_HIGH;
        if (rs_q != hi_rs_q) begin
          perr_d = 1'b1;
        end else begin
          w_byte_vld = 1'b1;
          w_byte     = {hi_nib_q, data_q};
        end
      end
    end

    if (w_byte_vld) begin
      if (rs_q) begin
        w_mem_we    = 1'b1;
        w_mem_waddr = ac_q;
        w_mem_wdata = w_byte;
        char_wr_d   = 1'b1;
        ac_d        = inc_q ? ac_q + 5'd1 : ac_q - 5'd1;
      end else begin
        // Command class is chosen by the highest set bit.
        casez (w_byte)
          8'b1???????: begin
            ac_d = {w_byte[6], w_byte[3:0]};
            if (|w_byte[5:4]) perr_d = 1'b1;
          end
          8'b01??????: ;
          8'b001?????: begin
            mode_4bit_d = ~w_byte[4];
            two_line_d  = w_byte[3];
            phase_d     = PH_HIGH;
          end
          8'b0001????: begin
            if (!w_byte[3]) ac_d = w_byte[2] ? ac_q + 5'd1 : ac_q - 5'd1;
          end
          8'b00001???: begin
            disp_d  = w_byte[2];
            cur_d   = w_byte[1];
            blink_d = w_byte[0];
          end
          8'b000001??: inc_d = w_byte[1];
          8'b0000001?: ac_d = 5'd0;
          8'b00000001: begin
            busy_d    = 1'b1;
            clr_cnt_d = '0;
            ac_d      = 5'd0;
            inc_d     = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    en_q   <= en;
    rs_q   <= rs;
    data_q <= data;
    if (reset) begin
      phase_q     <= PH_HIGH;
      hi_nib_q    <= 4'h0;
      hi_rs_q     <= 1'b0;
      mode_4bit_q <= 1'b0;
      two_line_q  <= 1'b0;
      disp_q      <= 1'b0;
      cur_q       <= 1'b0;
      blink_q     <= 1'b0;
      inc_q       <= 1'b1;
      ac_q        <= 5'd0;
      char_wr_q   <= 1'b0;
      perr_q      <= 1'b0;
      oerr_q      <= 1'b0;
      busy_q      <= 1'b1;
      clr_cnt_q   <= '0;
      rd_data_q   <= 8'h00;
    end else begin
      phase_q     <= phase_d;
      hi_nib_q    <= hi_nib_d;
      hi_rs_q     <= hi_rs_d;
      mode_4bit_q <= mode_4bit_d;
      two_line_q  <= two_line_d;
      disp_q      <= disp_d;
      cur_q       <= cur_d;
      blink_q     <= blink_d;
      inc_q       <= inc_d;
      ac_q        <= ac_d;
      char_wr_q   <= char_wr_d;
      perr_q      <= perr_d;
      oerr_q      <= oerr_d;
      busy_q      <= busy_d;
      clr_cnt_q   <= clr_cnt_d;
      rd_data_q   <= mem_q[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_mem_we) mem_q[w_mem_waddr] <= w_mem_wdata;
  end

  assign rd_data      = rd_data_q;
  assign busy         = busy_q;
  assign mode_4bit    = mode_4bit_q;
  assign two_line     = two_line_q;
  assign display_on   = disp_q;
  assign cursor_on    = cur_q;
  assign blink_on     = blink_q;
  assign cursor_addr  = ac_q;
  assign char_wr      = char_wr_q;
  assign protocol_err = perr_q;
  assign overrun_err  = oerr_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_receiver.sv
`default_nettype none
// ==== tb_lcd_receiver : directed self-checking bench for lcd_receiver ==== rev 1.0 ====
module tb_lcd_receiver;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       rs = 1'b0;
  logic [3:0] data = 4'h0;
  logic [4:0] rd_addr = 5'd0;
  logic [7:0] rd_data;
  logic       busy, mode_4bit, two_line, display_on, cursor_on, blink_on;
  logic [4:0] cursor_addr;
  logic       char_wr, protocol_err, overrun_err;

  int n_cmp  = 0;
  int n_fail = 0;
  int cw_cnt = 0;
  int fall;

  lcd_receiver #(.CLEAR_CYCLES(32)) dut (
    .clk(clk), .reset(reset), .en(en), .rs(rs), .data(data), .rd_addr(rd_addr),
    .rd_data(rd_data), .busy(busy), .mode_4bit(mode_4bit), .two_line(two_line),
    .display_on(display_on), .cursor_on(cursor_on), .blink_on(blink_on),
    .cursor_addr(cursor_addr), .char_wr(char_wr), .protocol_err(protocol_err),
    .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (char_wr) cw_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_nib(input logic r, input logic [3:0] n);
    en = 1'b1; rs = r; data = n;
    tick();
    en = 1'b0;
    tick();
  endtask

  task automatic send_byte(input logic r, input logic [7:0] b);
    send_nib(r, b[7:4]);
    send_nib(r, b[3:0]);
  endtask

  task automatic rd(input logic [4:0] a, input logic [7:0] exp, input string tag);
    rd_addr = a;
    tick();
    chk(tag, {24'h0, rd_data}, {24'h0, exp});
  endtask

  task automatic wait_fall(output int n);
    n = -1;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (!busy) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    // reset state
    repeat (3) tick();
    chk("rst_mode4", mode_4bit, 0);
    chk("rst_ac", cursor_addr, 0);
    chk("rst_charwr", char_wr, 0);
    chk("rst_perr", protocol_err, 0);
    chk("rst_oerr", overrun_err, 0);
    chk("rst_rddata", rd_data, 0);

    // power-up fill
    reset = 1'b0;
    wait_fall(fall);
    chk("fill_len", fall, 32);
    for (int a = 0; a < 32; a++) rd(5'(a), 8'h20, "fill_entry");
    chk("fill_mode4", mode_4bit, 0);

    // 4-bit init sequence
    send_nib(1'b0, 4'h3);
    send_nib(1'b0, 4'h3);
    send_nib(1'b0, 4'h3);
    send_nib(1'b0, 4'h2);
    send_byte(1'b0, 8'h28);
    send_byte(1'b0, 8'h0C);
    send_byte(1'b0, 8'h06);
    chk("init_mode4", mode_4bit, 1);
    chk("init_2line", two_line, 1);
    chk("init_disp", display_on, 1);
    chk("init_cur", cursor_on, 0);
    chk("init_blink", blink_on, 0);
    chk("init_perr", protocol_err, 0);
    chk("init_oerr", overrun_err, 0);

    // characters at home
    cw_cnt = 0;
    send_byte(1'b0, 8'h80);
    send_byte(1'b1, 8'h31);
    send_byte(1'b1, 8'h32);
    tick(); tick();
    chk("wr_pulses", cw_cnt, 2);
    chk("wr_ac", cursor_addr, 5'h02);
    rd(5'd0, 8'h31, "wr_d0");
    rd(5'd1, 8'h32, "wr_d1");

    // line wrap and decrement wrap
    send_byte(1'b0, 8'h8F);
    send_byte(1'b1, 8'h41);
    send_byte(1'b1, 8'h42);
    chk("wrap_ac", cursor_addr, 5'h11);
    rd(5'd15, 8'h41, "wrap_d15");
    rd(5'd16, 8'h42, "wrap_d16");
    send_byte(1'b0, 8'h80);
    send_byte(1'b0, 8'h04);
    send_byte(1'b1, 8'h43);
    chk("dec_ac", cursor_addr, 5'h1F);
    rd(5'd0, 8'h43, "dec_d0");
    send_byte(1'b0, 8'h14);
    chk("shift_inc_wrap", cursor_addr, 5'h00);
    send_byte(1'b0, 8'h10);
    chk("shift_dec_wrap", cursor_addr, 5'h1F);

    // clear with overrun
    cw_cnt = 0;
    send_byte(1'b0, 8'h01);
    chk("clr_busy", busy, 1);
    chk("clr_ac", cursor_addr, 0);
    repeat (3) tick();
    send_byte(1'b1, 8'h5A);
    chk("ovr_flag", overrun_err, 1);
    wait_fall(fall);
    chk("clr_len", fall, 25);
    chk("ovr_nowr", cw_cnt, 0);
    chk("ovr_ac", cursor_addr, 0);
    for (int a = 0; a < 32; a++) rd(5'(a), 8'h20, "clr_entry");

    // rs mismatch between nibbles
    send_byte(1'b0, 8'h08);
    chk("off_disp", display_on, 0);
    send_nib(1'b0, 4'h3);
    send_nib(1'b1, 4'h1);
    tick();
    chk("perr_flag", protocol_err, 1);
    chk("perr_nowr", cw_cnt, 0);
    chk("perr_ac", cursor_addr, 0);
    rd(5'd0, 8'h20, "perr_d0");
    send_byte(1'b0, 8'h0C);
    chk("post_disp", display_on, 1);
    chk("post_cur", cursor_on, 0);
    send_byte(1'b0, 8'h0F);
    chk("post_blink", blink_on, 1);
    send_byte(1'b1, 8'h5A);
    chk("post_inc_ac", cursor_addr, 5'h01);
    rd(5'd0, 8'h5A, "post_d0");

    // reset clears flags; reset mid-fill restarts the fill
    reset = 1'b1;
    tick(); tick();
    chk("rst2_perr", protocol_err, 0);
    chk("rst2_oerr", overrun_err, 0);
    chk("rst2_mode4", mode_4bit, 0);
    chk("rst2_ac", cursor_addr, 0);
    reset = 1'b0;
    repeat (10) tick();
    chk("mid_busy", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_fall(fall);
    chk("refill_len", fall, 32);

    // set-DDRAM with illegal bits loads truncated address
    send_nib(1'b0, 4'h2);
    chk("m4_again", mode_4bit, 1);
    send_byte(1'b0, 8'hA5);
    chk("ddram_bad_perr", protocol_err, 1);
    chk("ddram_bad_ac", cursor_addr, 5'h05);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lcd_receiver.md
LCD_RECEIVER -- requirements
Module: lcd_receiver

Interface
REQ-001 Parameter: CLEAR_CYCLES, default 32, number of clk cycles one clear-display fill takes (one DDRAM entry per cycle); SHALL be ≥32.
REQ-002 clk  in  1  sole clock, same domain as the LCD driver; all logic on posedge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 en  in  1  HD44780 enable strobe from the driver.
REQ-005 rs  in  1  register select: 0 command, 1 character data.
REQ-006 data  in  4  DB7..DB4 nibble.
REQ-007 rd_addr  in  5  DDRAM readout index {line, col[3:0]}.
REQ-008 rd_data  out  8  DDRAM[rd_addr], registered, 1-cycle latency.
REQ-009 busy  out  1  clear fill in progress.
REQ-010 mode_4bit, two_line, display_on, cursor_on, blink_on  out  1 each  decoded configuration state.
REQ-011 cursor_addr  out  5  address counter (AC).
REQ-012 char_wr  out  1  one-cycle pulse per DDRAM character write.
REQ-013 protocol_err, overrun_err  out  1 each  sticky error flags.

Function
REQ-014 en, rs and data SHALL be registered every cycle; a strobe SHALL be detected when registered en=1 and current en=0; the captured nibble/rs SHALL be the registered values from the last en-high cycle.
REQ-015 In 8-bit mode (mode_4bit=0) each strobe SHALL form a byte {nibble, 4'h0} and complete it immediately.
REQ-016 In 4-bit mode, strobes SHALL alternate high nibble then low nibble; the byte completes on the low nibble; phase SHALL return to high after each byte.
REQ-017 If rs of the low nibble differs from rs of the high nibble, the byte SHALL be discarded, protocol_err set, phase reset to high.
REQ-018 Completed command bytes (rs=0) SHALL decode by highest set bit: 0x01 clear; 0x02-0x03 AC=0; 0x04-0x07 increment=bit1 (shift ignored); 0x08-0x0F display_on=bit2, cursor_on=bit1, blink_on=bit0; 0x10-0x1F if bit3=0 AC +1 (bit2=1) or -1 (bit2=0), display shift ignored; 0x20-0x3F mode_4bit=~bit4, two_line=bit3, phase reset to high; 0x40-0x7F ignored (CGRAM not modelled); 0x80-0xFF AC={bit6, bit3..0}.
REQ-019 Set-DDRAM with byte[5:4]≠0 SHALL set protocol_err and still load truncated AC.
REQ-020 Data bytes (rs=1) SHALL write DDRAM[AC], pulse char_wr the following cycle, then step AC by +1/-1 per increment flag.
REQ-021 AC SHALL wrap modulo 32: 0x0F→0x10 (line 1 col 0), 0x1F→0x00, decrement 0x00→0x1F.
REQ-022 Clear SHALL assert busy the cycle after decode, write 0x20 to entries 0..31 one per cycle, set AC=0 and increment=1, and deassert busy after CLEAR_CYCLES cycles.
REQ-023 A strobe completing while busy=1 SHALL be dropped (no state change, nibble phase unchanged) and set overrun_err.
REQ-024 Nibble capture, decode and DDRAM write SHALL be one completed byte per strobe; no input buffering.
REQ-025 Error flags SHALL clear only on reset.

Reset
REQ-026 On reset: mode_4bit=0, two_line=0, display_on=0, cursor_on=0, blink_on=0, increment=1, AC=0, phase=high, char_wr=0, both errors=0, rd_data=0.
REQ-027 Release of reset SHALL start a clear fill (busy=1 for CLEAR_CYCLES cycles); reset asserted mid-fill SHALL restart the fill.

Verification
REQ-028 Reset, wait 40 cycles -> busy fell after 32 cycles; rd_data=0x20 for all 32 addresses; mode_4bit=0.
REQ-029 Strobes 3,3,3,2 (rs=0) then pairs 0x28,0x0C,0x06 -> mode_4bit=1, two_line=1, display_on=1, cursor_on=0, blink_on=0, no errors.
REQ-030 0x80 then rs=1 '1','2' -> DDRAM[0]=0x31, DDRAM[1]=0x32, cursor_addr=2, two char_wr pulses.
REQ-031 0x8F then 'A','B' -> DDRAM[15]=0x41, DDRAM[16]=0x42, cursor_addr=0x11; 0x04 then 'C' at AC=0 -> DDRAM[0]=0x43, cursor_addr=0x1F.
REQ-032 0x01 then full data pair 5 cycles later -> byte dropped, overrun_err=1, all entries 0x20, cursor_addr=0.
REQ-033 High nibble rs=0, low nibble rs=1 -> protocol_err=1, no DDRAM write; next correct pair 0x0C decodes normally.
